// File: rtl/sift_kp_pkg.sv
// Shared constants and types for the keypoint merge path.
package sift_kp_pkg;

   localparam int KP_WORD_W = 19;   // {row[8:0], col[9:0]}
   localparam int KP_ADDR_W = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } kp_state_e;

   // Layer tag stored in the SRAM word; equals the source stream index.
   localparam logic TAG_L0 = 1'b0;
   localparam logic TAG_L1 = 1'b1;

endpackage

// File: rtl/kp_fifo.sv
// Small synchronous FIFO; a push is taken when not full or when it pops in the same cycle.
module kp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 19
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_pop;
   logic         do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/keypoint_merge_arbiter.sv
// Merges two keypoint streams into one tagged SRAM write stream with frame sequencing.
module keypoint_merge_arbiter
   import sift_kp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = KP_ADDR_W,
   parameter int KP_W       = KP_WORD_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              frame_end,
   input  logic              kp0_we,
   input  logic [KP_W-1:0]   kp0_din,
   input  logic              kp1_we,
   input  logic [KP_W-1:0]   kp1_din,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [KP_W:0]     sram_din,
   output logic [ADDR_W:0]   kp_count,
   output logic [7:0]        drop_count,
   output logic              overflow,
   output logic              sram_full,
   output logic              done
);

   localparam logic [ADDR_W:0] SRAM_CAP = {1'b1, {ADDR_W{1'b0}}};

   kp_state_e       state;
   kp_state_e       state_nxt;
   logic            last_grant;
   logic            grant;
   logic            grant_valid;
   logic            accepting;
   logic            push0, push1, pop0, pop1;
   logic            empty0, empty1, full0, full1;
   logic [KP_W-1:0] head0, head1;
   logic            write_en, pop_drop, drop0, drop1;
   logic [1:0]      n_drops;
   logic [8:0]      drop_sum;

   kp_fifo #(.DEPTH(FIFO_DEPTH), .W(KP_W)) u_fifo0 (
      .clk(clk), .rst_n(rst_n), .clear(frame_start),
      .push(push0), .din(kp0_din), .pop(pop0),
      .dout(head0), .empty(empty0), .full(full0)
   );

   kp_fifo #(.DEPTH(FIFO_DEPTH), .W(KP_W)) u_fifo1 (
      .clk(clk), .rst_n(rst_n), .clear(frame_start),
      .push(push1), .din(kp1_din), .pop(pop1),
      .dout(head1), .empty(empty1), .full(full1)
   );

   assign accepting   = (state == ST_RUN) || (state == ST_DRAIN);
   assign push0       = kp0_we && accepting;
   assign push1       = kp1_we && accepting;
   assign grant_valid = !empty0 || !empty1;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      grant = last_grant;
      if (!empty0 && !empty1) grant = ~last_grant;
      else if (!empty0)       grant = TAG_L0;
      else if (!empty1)       grant = TAG_L1;
   end

   assign pop0      = grant_valid && (grant == TAG_L0);
   assign pop1      = grant_valid && (grant == TAG_L1);
   assign sram_full = (kp_count == SRAM_CAP);
   assign write_en  = grant_valid && !sram_full;
   assign pop_drop  = grant_valid && sram_full;
   assign drop0     = push0 && full0 && !pop0;
   assign drop1     = push1 && full1 && !pop1;
   assign n_drops   = {1'b0, drop0} + {1'b0, drop1} + {1'b0, pop_drop};
   assign drop_sum  = {1'b0, drop_count} + {7'b0, n_drops};
   assign done      = (state == ST_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  state_nxt = ST_IDLE;
         ST_RUN:   if (frame_end) state_nxt = ST_DRAIN;
         ST_DRAIN: if (empty0 && empty1 && !push0 && !push1) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // frame_start also re-arms the tie pointer so each frame's first tie goes to stream 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= TAG_L1;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_din   <= '0;
         kp_count   <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else if (frame_start) begin
         state      <= ST_RUN;
         last_grant <= TAG_L1;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         kp_count   <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         state   <= state_nxt;
         sram_we <= write_en;
         if (grant_valid) last_grant <= grant;
         if (write_en) begin
            sram_addr <= kp_count[ADDR_W-1:0];
            sram_din  <= {grant, (grant == TAG_L1) ? head1 : head0};
            kp_count  <= kp_count + (ADDR_W+1)'(1);
         end
         if (n_drops != 2'd0) begin
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            overflow   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_keypoint_merge_arbiter.sv
// Randomised bench for keypoint_merge_arbiter against a queue-based frame model.
module tb_keypoint_merge_arbiter;

   localparam int KP_W  = 19;
   localparam int ADDR_W = 11;
   localparam int DEPTH = 4;
   localparam int CAP   = 2048;

   logic              clk;
   logic              rst_n;
   logic              frame_start, frame_end;
   logic              kp0_we, kp1_we;
   logic [KP_W-1:0]   kp0_din, kp1_din;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [KP_W:0]     sram_din;
   logic [ADDR_W:0]   kp_count;
   logic [7:0]        drop_count;
   logic              overflow, sram_full, done;

   keypoint_merge_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .KP_W(KP_W)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
      .kp0_we(kp0_we), .kp0_din(kp0_din), .kp1_we(kp1_we), .kp1_din(kp1_din),
      .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din),
      .kp_count(kp_count), .drop_count(drop_count), .overflow(overflow),
      .sram_full(sram_full), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: one queue per stream, phase 0 idle / 1 run / 2 drain / 3 done.
   logic [KP_W-1:0] q0[$];
   logic [KP_W-1:0] q1[$];
   int              m_phase, m_last, m_count, m_drops, m_addr;
   bit              m_ovf, m_we;
   logic [KP_W:0]   m_din;

   task automatic add_drop();
      if (m_drops < 255) m_drops++;
      m_ovf = 1'b1;
   endtask

   always @(posedge clk) begin
      int  g;
      bit  e0, e1, open;
      logic [KP_W-1:0] w;
      if (!rst_n) begin
         q0.delete(); q1.delete();
         m_phase = 0; m_last = 1; m_count = 0; m_drops = 0; m_addr = 0;
         m_ovf = 0; m_we = 0; m_din = '0;
      end else if (frame_start) begin
         q0.delete(); q1.delete();
         m_phase = 1; m_last = 1; m_count = 0; m_drops = 0; m_addr = 0;
         m_ovf = 0; m_we = 0;
      end else begin
         e0   = (q0.size() == 0);
         e1   = (q1.size() == 0);
         open = (m_phase == 1) || (m_phase == 2);
         if (!e0 && !e1) g = 1 - m_last;
         else if (!e0)   g = 0;
         else if (!e1)   g = 1;
         else            g = -1;
         m_we = 0;
         if (g >= 0) begin
            w = (g == 1) ? q1.pop_front() : q0.pop_front();
            m_last = g;
            if (m_count < CAP) begin
               m_we = 1; m_addr = m_count; m_din = {g[0], w}; m_count++;
            end else add_drop();
         end
         if (open && kp0_we) begin
            if (q0.size() < DEPTH) q0.push_back(kp0_din); else add_drop();
         end
         if (open && kp1_we) begin
            if (q1.size() < DEPTH) q1.push_back(kp1_din); else add_drop();
         end
         if (m_phase == 1 && frame_end) m_phase = 2;
         else if (m_phase == 2 && e0 && e1 && !kp0_we && !kp1_we) m_phase = 3;
      end
   end

   logic [ADDR_W+KP_W:0] wlog[$];

   always @(negedge clk) begin
      if (cmp_en) begin
         check("sram_we", sram_we, m_we);
         check("sram_addr", sram_addr, m_addr);
         if (m_we) check("sram_din", sram_din, m_din);
         check("kp_count", kp_count, m_count);
         check("drop_count", drop_count, m_drops);
         check("overflow", overflow, m_ovf);
         check("sram_full", sram_full, m_count == CAP);
         check("done", done, m_phase == 3);
         if (sram_we) wlog.push_back({sram_addr, sram_din});
      end
   end

   task automatic step(input bit fs, input bit fe, input bit w0, input logic [KP_W-1:0] d0,
                       input bit w1, input logic [KP_W-1:0] d1);
      frame_start = fs; frame_end = fe;
      kp0_we = w0; kp0_din = d0; kp1_we = w1; kp1_din = d1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0);
   endtask

   task automatic rstep(input bit fe, input int p0, input int p1);
      step(0, fe, $urandom_range(0, 99) < p0, KP_W'($urandom),
                  $urandom_range(0, 99) < p1, KP_W'($urandom));
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         idle(1);
         n++;
      end
      check(name, done, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      frame_start = 0; frame_end = 0; kp0_we = 0; kp1_we = 0; kp0_din = '0; kp1_din = '0;
      @(negedge clk); @(negedge clk);
      cmp_en = 1'b1;
      check("reset sram_we", sram_we, 0);
      check("reset kp_count", kp_count, 0);
      check("reset done", done, 0);
      rst_n = 1'b1;
      idle(2);

      // Single keypoint: written two cycles after the push, then done.
      step(1, 0, 0, '0, 0, '0);
      step(0, 0, 1, 19'h0A005, 0, '0);
      check("single latency", sram_we, 0);
      idle(1);
      check("single we", sram_we, 1);
      check("single addr", sram_addr, 0);
      check("single din", sram_din, 20'h0A005);
      step(0, 1, 0, '0, 0, '0);
      idle(1);
      check("single done", done, 1);
      check("single count", kp_count, 1);

      // Simultaneous pushes alternate tags starting with stream 0.
      step(1, 0, 0, '0, 0, '0);
      wlog.delete();
      for (int i = 0; i < 3; i++) step(0, i == 2, 1, KP_W'(i), 1, KP_W'(16 + i));
      wait_done(20, "pair done");
      check("pair writes", wlog.size(), 6);
      for (int i = 0; i < 6 && i < wlog.size(); i++) begin
         check("pair tag", wlog[i][KP_W], i % 2);
         check("pair addr", wlog[i][ADDR_W+KP_W:KP_W+1], i);
      end
      check("pair drops", drop_count, 0);

      // Five cycles of dual pushes fit in the FIFOs; ten cycles overflow by three.
      step(1, 0, 0, '0, 0, '0);
      for (int i = 0; i < 5; i++) step(0, i == 4, 1, KP_W'($urandom), 1, KP_W'($urandom));
      wait_done(20, "burst5 done");
      check("burst5 total", kp_count + drop_count, 10);
      check("burst5 drops", drop_count, 0);
      step(1, 0, 0, '0, 0, '0);
      for (int i = 0; i < 10; i++) step(0, i == 9, 1, KP_W'($urandom), 1, KP_W'($urandom));
      wait_done(20, "burst10 done");
      check("burst10 drops", drop_count, 3);
      check("burst10 count", kp_count, 17);
      check("burst10 overflow", overflow, 1);

      // SRAM full: 2050 keypoints, two dropped, address never wraps.
      step(1, 0, 0, '0, 0, '0);
      wlog.delete();
      for (int i = 0; i < 2050; i++) step(0, i == 2049, 1, KP_W'(i), 0, '0);
      wait_done(10, "full done");
      check("full count", kp_count, CAP);
      check("full drops", drop_count, 2);
      check("full flag", sram_full, 1);
      check("full writes", wlog.size(), CAP);
      if (wlog.size() > 0) check("full last addr", wlog[wlog.size()-1][ADDR_W+KP_W:KP_W+1], CAP - 1);

      // Abort in drain with three keypoints queued.
      step(1, 0, 0, '0, 0, '0);
      step(0, 0, 1, 19'h00111, 1, 19'h00222);
      step(0, 1, 1, 19'h00333, 1, 19'h00444);
      step(1, 0, 0, '0, 0, '0);
      wlog.delete();
      check("abort count", kp_count, 0);
      check("abort we", sram_we, 0);
      idle(3);
      check("abort stale writes", wlog.size(), 0);
      step(0, 0, 0, '0, 1, 19'h055AA);
      idle(1);
      check("abort new addr", sram_addr, 0);
      check("abort new din", sram_din, {1'b1, 19'h055AA});

      // Reset mid-frame while writes are flowing.
      step(1, 0, 0, '0, 0, '0);
      for (int i = 0; i < 4; i++) step(0, 0, 1, KP_W'($urandom), 1, KP_W'($urandom));
      rst_n = 1'b0;
      step(0, 0, 1, KP_W'($urandom), 1, KP_W'($urandom));
      rst_n = 1'b1;
      check("rst we", sram_we, 0);
      check("rst count", kp_count, 0);
      check("rst addr", sram_addr, 0);
      check("rst done", done, 0);
      wlog.delete();
      for (int i = 0; i < 4; i++) step(0, 0, 1, KP_W'($urandom), 1, KP_W'($urandom));
      idle(2);
      check("rst no writes", wlog.size(), 0);

      // Randomised frames: normal, abort-in-drain, abort-in-run.
      for (int f = 0; f < 16; f++) begin
         int len, p0, p1, mode;
         len  = $urandom_range(10, 60);
         p0   = $urandom_range(0, 100);
         p1   = $urandom_range(0, 100);
         mode = $urandom_range(0, 3);
         step(1, f == 5, 0, '0, 0, '0);
         for (int c = 0; c < len; c++) begin
            if (mode == 3 && c == len / 2) step(1, 0, 0, '0, 0, '0);
            else rstep(c == len - 1, p0, p1);
         end
         for (int c = 0; c < 3; c++) rstep(0, p0 / 2, p1 / 2);
         if (mode != 2) begin
            wait_done(40, "rand done");
            for (int c = 0; c < 3; c++) rstep(0, 50, 50);
         end
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
